// File: rtl/mem_bus_responder_pkg.sv
// Shared types and constants for the 6502 memory-side bus responder.
// Holds the FSM state enum, the latched request layout, the data_OUT source
// selector and the bus constants used by mem_bus_responder and its bench.
package bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} bus_state_t;

    // Where data_OUT currently comes from. ZERO is the post-reset value,
    // RAM is the read register of bus_ram, OPEN is the floating-bus constant.
    typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_OPEN} data_sel_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;     // 1 = read, 0 = write
        logic [7:0]  wdata;
    } bus_req_t;

    localparam logic [7:0]  BUS_OPEN_VALUE         = 8'hFF;
    localparam logic [15:0] BUS_WINDOW_TOP_DEFAULT = 16'h2000;

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU-side bus bundle for mem_bus_responder.
//   master: the CPU (or bench) driving address/rw/cycle_EN/data_IN
//   slave : the responder returning data_OUT, rdy_OUT, done_OUT, range_ERR_OUT
interface mem_bus_responder_if;

    logic [7:0] addressHigh_IN;
    logic [7:0] addressLow_IN;
    logic       rw_IN;
    logic       cycle_EN;
    logic [7:0] data_IN;
    logic [7:0] data_OUT;
    logic       rdy_OUT;
    logic       done_OUT;
    logic       range_ERR_OUT;

    modport master (
        output addressHigh_IN, addressLow_IN, rw_IN, cycle_EN, data_IN,
        input  data_OUT, rdy_OUT, done_OUT, range_ERR_OUT
    );

    modport slave (
        input  addressHigh_IN, addressLow_IN, rw_IN, cycle_EN, data_IN,
        output data_OUT, rdy_OUT, done_OUT, range_ERR_OUT
    );

endinterface

// File: rtl/mem_bus_responder_ram.sv
// bus_ram: single-port synchronous RAM, MEM_DEPTH x 8, no reset.
//   clk   : write and read clock
//   we    : write enable, wdata stored at addr
//   re    : read enable, rdata loads mem[addr]; rdata holds when re is low
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module bus_ram #(
    parameter int MEM_DEPTH = 2048,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: far end of the 6502 address/data bus. Accepts one bus
// cycle, stalls the CPU for WAIT_STATES clocks via rdy_OUT, then acknowledges
// with a one-cycle done_OUT. Addresses below WINDOW_TOP hit a MEM_DEPTH-byte
// RAM mirrored across the window; others raise range_ERR_OUT and drop writes.
//   phi2   : clock, rising edge
//   reset  : asynchronous, active high
//   bus    : mem_bus_responder_if.slave (request in, data/rdy/done/err out)
// Build option: MEM_BUS_RESPONDER_OPEN_BUS_EN defined -> out-of-window reads
// leave data_OUT unchanged; otherwise they return BUS_OPEN_VALUE.
module mem_bus_responder
    import bus_pkg::*;
#(
    parameter int          WAIT_STATES = 2,
    parameter int          MEM_DEPTH   = 2048,
    parameter logic [15:0] WINDOW_TOP  = BUS_WINDOW_TOP_DEFAULT
) (
    input  logic               phi2,
    input  logic               reset,
    mem_bus_responder_if.slave bus
);

    localparam int AW = $clog2(MEM_DEPTH);

`ifdef MEM_BUS_RESPONDER_OPEN_BUS_EN
    localparam bit OPEN_BUS = 1'b1;
`else
    localparam bit OPEN_BUS = 1'b0;
`endif

    bus_state_t state;
    logic [3:0] cnt;
    bus_req_t   lat;
    data_sel_t  sel;
    logic       rdy;
    logic       done;
    logic       err;

    bus_req_t   in_req;
    bus_req_t   cur;
    logic       accept;
    logic       enter_ack;
    logic       in_win;
    logic       ram_we;
    logic       ram_re;
    logic [7:0] ram_rdata;

    assign in_req = '{addr:  {bus.addressHigh_IN, bus.addressLow_IN},
                      rw:    bus.rw_IN,
                      wdata: bus.data_IN};

    // IDLE and ACK both accept; WAIT ignores cycle_EN.
    assign accept = (state != WAIT) && bus.cycle_EN;

    // With zero wait states the accepting edge is also the edge entering ACK,
    // so the RAM must see the live request rather than the latched copy.
    assign cur       = (state == WAIT) ? lat : in_req;
    assign enter_ack = ((state == WAIT) && (cnt == '0)) ||
                       (accept && (WAIT_STATES == 0));
    assign in_win    = cur.addr < WINDOW_TOP;

    // RAM access happens only on the edge entering ACK, so an aborted cycle
    // (reset during WAIT) never touches memory.
    assign ram_we = enter_ack && !cur.rw && in_win;
    assign ram_re = enter_ack &&  cur.rw && in_win;

    bus_ram #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
        .clk   (phi2),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur.addr[AW-1:0]),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
            sel   <= SEL_ZERO;
            rdy   <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
        end else if (enter_ack) begin
            state <= ACK;
            rdy   <= 1'b1;
            done  <= 1'b1;
            err   <= !in_win;
            if (cur.rw) begin
                if (in_win)        sel <= SEL_RAM;
                else if (!OPEN_BUS) sel <= SEL_OPEN;
            end
        end else if (accept) begin
            state <= WAIT;
            cnt   <= 4'(WAIT_STATES - 1);
            lat   <= in_req;
            rdy   <= 1'b0;
            done  <= 1'b0;
        end else if (state == WAIT) begin
            cnt   <= cnt - 4'd1;
            rdy   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= IDLE;
            rdy   <= 1'b1;
            done  <= 1'b0;
        end
    end

    // data_OUT is a pure function of registered state: the selector and the
    // RAM read register, which only loads on in-window read acknowledges.
    assign bus.data_OUT      = (sel == SEL_RAM)  ? ram_rdata :
                               (sel == SEL_OPEN) ? BUS_OPEN_VALUE : 8'h00;
    assign bus.rdy_OUT       = rdy;
    assign bus.done_OUT      = done;
    assign bus.range_ERR_OUT = err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with WAIT_STATES=2, one with 0.
// A behavioural model predicts data_OUT/range_ERR_OUT per request and pushes
// them into a per-instance queue; a monitor pops on every done_OUT.
module tb_mem_bus_responder;

    logic phi2  = 1'b0;
    logic reset = 1'b1;
    always #5 phi2 = ~phi2;

    mem_bus_responder_if b2();
    mem_bus_responder_if b0();

    mem_bus_responder #(.WAIT_STATES(2)) dut2 (.phi2(phi2), .reset(reset), .bus(b2.slave));
    mem_bus_responder #(.WAIT_STATES(0)) dut0 (.phi2(phi2), .reset(reset), .bus(b0.slave));

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       q2[$];
    exp_t       q0[$];
    logic [7:0] m2 [2048];
    logic [7:0] m0 [2048];
    logic [7:0] cur2 = 8'h00;
    logic [7:0] cur0 = 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour of one acknowledged bus cycle.
    task automatic model(input int d, input logic [15:0] a, input logic rw, input logic [7:0] wd);
        exp_t       e;
        logic       win;
        logic [10:0] i;
        logic [7:0] cur;
        win = a < 16'h2000;
        i   = a[10:0];
        cur = (d == 0) ? cur0 : cur2;
        if (rw) begin
            if (win) cur = (d == 0) ? m0[i] : m2[i];
`ifdef MEM_BUS_RESPONDER_OPEN_BUS_EN
            else cur = cur;
`else
            else cur = 8'hFF;
`endif
        end else if (win) begin
            if (d == 0) m0[i] = wd; else m2[i] = wd;
        end
        e.data = cur;
        e.err  = !win;
        if (d == 0) begin cur0 = cur; q0.push_back(e); end
        else        begin cur2 = cur; q2.push_back(e); end
    endtask

    always @(negedge phi2) begin
        exp_t e;
        if (!reset) begin
            if (b2.done_OUT) begin
                if (q2.size() == 0) chk("dut2_spurious_done", 16'd1, 16'd0);
                else begin
                    e = q2.pop_front();
                    chk("dut2_data", 16'(b2.data_OUT), 16'(e.data));
                    chk("dut2_err",  16'(b2.range_ERR_OUT), 16'(e.err));
                end
            end
            if (b0.done_OUT) begin
                if (q0.size() == 0) chk("dut0_spurious_done", 16'd1, 16'd0);
                else begin
                    e = q0.pop_front();
                    chk("dut0_data", 16'(b0.data_OUT), 16'(e.data));
                    chk("dut0_err",  16'(b0.range_ERR_OUT), 16'(e.err));
                end
            end
        end
    end

    // One request on the WAIT_STATES=2 instance, with timing checks.
    // disturb: change address/data and pulse cycle_EN during WAIT.
    task automatic req2(input logic [15:0] a, input logic rw, input logic [7:0] wd, input bit disturb);
        logic [15:0] ga;
        @(negedge phi2);
        b2.addressHigh_IN = a[15:8];
        b2.addressLow_IN  = a[7:0];
        b2.rw_IN          = rw;
        b2.data_IN        = wd;
        b2.cycle_EN       = 1'b1;
        model(2, a, rw, wd);
        @(negedge phi2);
        b2.cycle_EN = 1'b0;
        chk("ws_rdy_n1",  16'(b2.rdy_OUT),  16'd0);
        chk("ws_done_n1", 16'(b2.done_OUT), 16'd0);
        if (disturb) begin
            ga = a ^ 16'h0001;
            b2.addressHigh_IN = ga[15:8];
            b2.addressLow_IN  = ga[7:0];
            b2.data_IN        = ~wd;
            b2.rw_IN          = ~rw;
            b2.cycle_EN       = 1'b1;
        end
        @(negedge phi2);
        b2.cycle_EN = 1'b0;
        chk("ws_rdy_n2",  16'(b2.rdy_OUT),  16'd0);
        chk("ws_done_n2", 16'(b2.done_OUT), 16'd0);
        @(negedge phi2);
        chk("ack_done", 16'(b2.done_OUT), 16'd1);
        chk("ack_rdy",  16'(b2.rdy_OUT),  16'd1);
    endtask

    initial begin
        logic [15:0] a;
        b2.addressHigh_IN = '0; b2.addressLow_IN = '0; b2.rw_IN = 1'b1;
        b2.data_IN = '0; b2.cycle_EN = 1'b0;
        b0.addressHigh_IN = '0; b0.addressLow_IN = '0; b0.rw_IN = 1'b1;
        b0.data_IN = '0; b0.cycle_EN = 1'b0;

        // Reset state
        repeat (2) @(negedge phi2);
        chk("rst_rdy",  16'(b2.rdy_OUT),       16'd1);
        chk("rst_done", 16'(b2.done_OUT),      16'd0);
        chk("rst_err",  16'(b2.range_ERR_OUT), 16'd0);
        chk("rst_data", 16'(b2.data_OUT),      16'h00);
        chk("rst_data0", 16'(b0.data_OUT),     16'h00);
        reset = 1'b0;

        // Basic write then read; also preload $0200 for the reset test
        req2(16'h0123, 1'b0, 8'h5A, 1'b0);
        req2(16'h0123, 1'b1, 8'h00, 1'b0);
        req2(16'h0200, 1'b0, 8'h00, 1'b0);

        // Mirroring
        req2(16'h0010, 1'b0, 8'hC3, 1'b0);
        req2(16'h0810, 1'b1, 8'h00, 1'b0);
        req2(16'h1010, 1'b1, 8'h00, 1'b0);
        req2(16'h1810, 1'b1, 8'h00, 1'b0);

        // Ignored inputs during WAIT
        req2(16'h0301, 1'b0, 8'h01, 1'b0);
        req2(16'h0300, 1'b0, 8'h3C, 1'b1);
        req2(16'h0300, 1'b1, 8'h00, 1'b0);
        req2(16'h0301, 1'b1, 8'h00, 1'b1);

        // Out of window
        req2(16'h0000, 1'b0, 8'h11, 1'b0);
        req2(16'h0000, 1'b1, 8'h00, 1'b0);
        req2(16'h4016, 1'b1, 8'h00, 1'b0);
        req2(16'h0000, 1'b1, 8'h00, 1'b0);
        req2(16'h4016, 1'b1, 8'h00, 1'b0);
        req2(16'h2000, 1'b0, 8'h77, 1'b0);
        req2(16'h0000, 1'b1, 8'h00, 1'b0);
        req2(16'h2000, 1'b0, 8'h77, 1'b0);

        // Back-to-back on the zero-wait instance: four writes, four reads
        @(negedge phi2);
        for (int k = 0; k < 8; k++) begin
            a = (k < 4) ? 16'(k) : 16'(k - 4);
            b0.addressHigh_IN = a[15:8];
            b0.addressLow_IN  = a[7:0];
            b0.rw_IN          = (k >= 4);
            b0.data_IN        = 8'(8'hA0 + k);
            b0.cycle_EN       = 1'b1;
            model(0, a, (k >= 4), 8'(8'hA0 + k));
            @(negedge phi2);
            chk("b2b_done", 16'(b0.done_OUT), 16'd1);
            chk("b2b_rdy",  16'(b0.rdy_OUT),  16'd1);
        end
        b0.cycle_EN = 1'b0;
        @(negedge phi2);
        chk("b2b_idle_done", 16'(b0.done_OUT), 16'd0);

        // Reset mid-operation: write $0200<-99 accepted, reset during WAIT
        @(negedge phi2);
        b2.addressHigh_IN = 8'h02; b2.addressLow_IN = 8'h00;
        b2.rw_IN = 1'b0; b2.data_IN = 8'h99; b2.cycle_EN = 1'b1;
        @(negedge phi2);
        b2.cycle_EN = 1'b0;
        chk("pre_rst_rdy", 16'(b2.rdy_OUT), 16'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_rdy",  16'(b2.rdy_OUT),       16'd1);
        chk("arst_done", 16'(b2.done_OUT),      16'd0);
        chk("arst_err",  16'(b2.range_ERR_OUT), 16'd0);
        chk("arst_data", 16'(b2.data_OUT),      16'h00);
        chk("arst_data0", 16'(b0.data_OUT),     16'h00);
        q2.delete(); q0.delete();
        cur2 = 8'h00; cur0 = 8'h00;
        @(negedge phi2);
        reset = 1'b0;
        req2(16'h0200, 1'b1, 8'h00, 1'b0);

        repeat (4) @(negedge phi2);
        chk("q2_drain", 16'(q2.size()), 16'd0);
        chk("q0_drain", 16'(q0.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
